// File: rtl/manch_pkg.sv
// Shared types and constants for the Manchester transmit path.
// Imported by the scheduler and its round-robin arbiter.
package manch_pkg;

  localparam int MANCH_N_DEFAULT = 9;
  localparam int HALF_PER_BIT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

endpackage : manch_pkg

// File: rtl/manch_rr_arb2.sv
// Combinational two-way round-robin pick.
// When both sources request, the one that did not win last time is picked.
module manch_rr_arb2
  import manch_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  src_e last_src,
  output src_e winner,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = (last_src == SRC0) ? SRC1 : SRC0;
    end else if (req1) begin
      winner = SRC1;
    end else begin
      winner = SRC0;
    end
  end

endmodule : manch_rr_arb2

// File: rtl/manch_tx_sched.sv
// Two-source transmit scheduler: grants a word, drives the encoder's go for
// 2N half-bit cycles, then holds an idle gap before the next grant.
module manch_tx_sched
  import manch_pkg::*;
#(
  parameter int N   = MANCH_N_DEFAULT,
  parameter int GAP = 4
) (
  input  logic         clk_2x,
  input  logic         rst,
  input  logic         en,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         enc_go,
  output logic [N-1:0] enc_data,
  output logic         busy,
  output logic         frame_done,
  output logic         active_src
);

  localparam int               CNT_W     = $clog2(HALF_PER_BIT * N);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_PER_BIT * N - 1);
  localparam logic [7:0]       GCNT_LAST = 8'(GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             enc_go_q, enc_go_d;
  logic [N-1:0]     enc_data_q, enc_data_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  src_e             active_src_q, active_src_d;
  src_e             last_src_q, last_src_d;

  src_e             arb_winner;
  logic             arb_valid;

  manch_rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_src (last_src_q),
    .winner   (arb_winner),
    .valid    (arb_valid)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    enc_go_d     = enc_go_q;
    enc_data_d   = enc_data_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    frame_done_d = 1'b0;
    active_src_d = active_src_q;
    last_src_d   = last_src_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en && arb_valid) begin
          enc_data_d   = (arb_winner == SRC1) ? data1 : data0;
          gnt0_d       = (arb_winner == SRC0);
          gnt1_d       = (arb_winner == SRC1);
          enc_go_d     = 1'b1;
          active_src_d = arb_winner;
          last_src_d   = arb_winner;
          cnt_d        = '0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == CNT_LAST) begin
          enc_go_d     = 1'b0;
          frame_done_d = 1'b1;
          cnt_d        = '0;
          gcnt_d       = '0;
          state_d      = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_q == GCNT_LAST) begin
          gcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered from the next state so busy lines up with SEND/GAP exactly.
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state is written with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_2x or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      enc_go_q     <= 1'b0;
      enc_data_q   <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      active_src_q <= SRC0;
      last_src_q   <= SRC1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
      enc_go_q     <= enc_go_d;
      enc_data_q   <= enc_data_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      active_src_q <= active_src_d;
      last_src_q   <= last_src_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign enc_go     = enc_go_q;
  assign enc_data   = enc_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign active_src = active_src_q;

endmodule : manch_tx_sched

// File: tb/tb_manch_tx_sched.sv
// Directed bench for manch_tx_sched with N=9, GAP=4 (frame period 23).
// Inputs change and outputs are observed on the falling edge.
module tb_manch_tx_sched;

  localparam int N   = 9;
  localparam int GAP = 4;

  logic         clk_2x = 1'b0;
  logic         rst;
  logic         en;
  logic         req0, req1;
  logic [N-1:0] data0, data1;
  logic         gnt0, gnt1;
  logic         enc_go;
  logic [N-1:0] enc_data;
  logic         busy;
  logic         frame_done;
  logic         active_src;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_2x = ~clk_2x;

  manch_tx_sched #(.N(N), .GAP(GAP)) dut (
    .clk_2x     (clk_2x),
    .rst        (rst),
    .en         (en),
    .req0       (req0),
    .req1       (req1),
    .data0      (data0),
    .data1      (data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .enc_go     (enc_go),
    .enc_data   (enc_data),
    .busy       (busy),
    .frame_done (frame_done),
    .active_src (active_src)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2x);
    @(negedge clk_2x);
  endtask

  task automatic do_reset();
    en = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until a grant is seen; waited = edges consumed.
  task automatic wait_grant(input string tag, input int budget, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(gnt0 || gnt1) && waited < budget);
    check({tag, "_grant_seen"}, 32'(gnt0 | gnt1), 32'd1);
  endtask

  // Called just after a grant edge. Counts enc_go-high cycles, frame_done
  // pulses and the busy cycles that follow enc_go falling.
  task automatic watch_frame(input int drop_en_at, output int go_len,
                             output int fd_cnt, output int gap_len, output int gnt_cnt);
    go_len = 0; fd_cnt = 0; gap_len = 0; gnt_cnt = 0;
    while (enc_go && go_len < 100) begin
      go_len++;
      if (go_len == drop_en_at) en = 1'b0;
      tick();
      if (frame_done) fd_cnt++;
      if (gnt0 || gnt1) gnt_cnt++;
    end
    while (busy && gap_len < 100) begin
      gap_len++;
      tick();
      if (frame_done) fd_cnt++;
      if (gnt0 || gnt1) gnt_cnt++;
    end
  endtask

  int go_len, fd_cnt, gap_len, gnt_cnt, waited, seen;
  logic [N-1:0] exp_word;

  initial begin
    rst = 1'b1; en = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;

    // Reset state
    do_reset();
    check("rst_enc_go", 32'(enc_go), 32'd0);
    check("rst_enc_data", 32'(enc_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_active_src", 32'(active_src), 32'd0);

    // Single frame from source 0
    req0 = 1'b1; data0 = 9'h15B;
    tick();
    check("t1_gnt0", 32'(gnt0), 32'd1);
    check("t1_gnt1", 32'(gnt1), 32'd0);
    check("t1_enc_go", 32'(enc_go), 32'd1);
    check("t1_enc_data", 32'(enc_data), 32'h15B);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_active_src", 32'(active_src), 32'd0);
    req0 = 1'b0; data0 = 9'h000;
    watch_frame(-1, go_len, fd_cnt, gap_len, gnt_cnt);
    check("t1_go_len", 32'(go_len), 32'd18);
    check("t1_frame_done_cnt", 32'(fd_cnt), 32'd1);
    check("t1_gap_len", 32'(gap_len), 32'd4);
    check("t1_extra_gnt", 32'(gnt_cnt), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_data_held", 32'(enc_data), 32'h15B);

    // Contention: both held, grants alternate 0,1,0,1 every 23 cycles
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 9'h0A5; data1 = 9'h1C3;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t2", 60, waited);
      exp_word = (k % 2 == 1) ? 9'h1C3 : 9'h0A5;
      check("t2_gnt1", 32'(gnt1), 32'(k % 2));
      check("t2_gnt0", 32'(gnt0), 32'(1 - k % 2));
      check("t2_active_src", 32'(active_src), 32'(k % 2));
      check("t2_enc_data", 32'(enc_data), 32'(exp_word));
      check("t2_interval", 32'(waited), (k == 0) ? 32'd1 : 32'd23);
    end

    // Lone requester: source 1 wins every time even though last_src starts at 1
    do_reset();
    req1 = 1'b1; data1 = 9'h17E;
    for (int k = 0; k < 3; k++) begin
      wait_grant("t3", 60, waited);
      check("t3_gnt1", 32'(gnt1), 32'd1);
      check("t3_active_src", 32'(active_src), 32'd1);
      check("t3_enc_data", 32'(enc_data), 32'h17E);
      check("t3_interval", 32'(waited), (k == 0) ? 32'd1 : 32'd23);
    end

    // en low blocks grants; raising it grants on the first IDLE edge
    do_reset();
    en = 1'b0; req0 = 1'b1; data0 = 9'h033;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gnt0 || gnt1 || busy) seen++;
    end
    check("t4_blocked", 32'(seen), 32'd0);
    en = 1'b1;
    tick();
    check("t4_gnt0", 32'(gnt0), 32'd1);
    check("t4_enc_data", 32'(enc_data), 32'h033);

    // en dropped before E5 mid-frame: frame finishes, no new grant
    do_reset();
    req0 = 1'b1; data0 = 9'h0F0;
    tick();
    check("t5_gnt0", 32'(gnt0), 32'd1);
    watch_frame(5, go_len, fd_cnt, gap_len, gnt_cnt);
    check("t5_go_len", 32'(go_len), 32'd18);
    check("t5_frame_done_cnt", 32'(fd_cnt), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gnt0 || gnt1 || enc_go) seen++;
    end
    check("t5_no_regrant", 32'(gnt_cnt + seen), 32'd0);

    // Reset mid-frame: async drop, no frame_done, source 0 first afterwards
    do_reset();
    req0 = 1'b1; data0 = 9'h1AA; data1 = 9'h055;
    tick();
    check("t6_gnt0", 32'(gnt0), 32'd1);
    for (int i = 0; i < 9; i++) tick();
    check("t6_go_pre", 32'(enc_go), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_go", 32'(enc_go), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("t6_async_data", 32'(enc_data), 32'd0);
    @(negedge clk_2x);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (frame_done || enc_go) seen++;
    end
    check("t6_no_frame_done", 32'(seen), 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b0;
    wait_grant("t6", 5, waited);
    check("t6_first_src0", 32'(gnt0), 32'd1);
    check("t6_latency", 32'(waited), 32'd1);
    check("t6_enc_data", 32'(enc_data), 32'h1AA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_manch_tx_sched
